// File: rtl/cla_share_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter in front of one 16-bit CLA adder.
// Holds the FSM state type, the datapath width and the requester id constants.
package cla_share_arbiter_pkg;

    localparam int WIDTH = 16;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups whose
// group generate/propagate terms feed a second lookahead level.
module cla16
    import cla_share_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [3:0]       w_gp;
    logic [3:0]       w_gg;
    logic [4:0]       w_grp_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
        logic [3:0] w_p4;
        logic [3:0] w_g4;
        logic       w_c0;
        logic [3:0] w_c;

        assign w_p4 = w_p[4*gi +: 4];
        assign w_g4 = w_g[4*gi +: 4];
        assign w_c0 = w_grp_c[gi];

        // Every bit carry is expanded from the group carry-in, never rippled.
        assign w_c[0] = w_c0;
        assign w_c[1] = w_g4[0] | (w_p4[0] & w_c0);
        assign w_c[2] = w_g4[1] | (w_p4[1] & w_g4[0]) | (w_p4[1] & w_p4[0] & w_c0);
        assign w_c[3] = w_g4[2] | (w_p4[2] & w_g4[1]) | (w_p4[2] & w_p4[1] & w_g4[0])
                      | (w_p4[2] & w_p4[1] & w_p4[0] & w_c0);

        assign w_gp[gi] = &w_p4;
        assign w_gg[gi] = w_g4[3] | (w_p4[3] & w_g4[2]) | (w_p4[3] & w_p4[2] & w_g4[1])
                        | (w_p4[3] & w_p4[2] & w_p4[1] & w_g4[0]);

        assign o_sum[4*gi +: 4] = w_p4 ^ w_c;
    end

    assign w_grp_c[0] = i_cin;
    assign w_grp_c[1] = w_gg[0] | (w_gp[0] & i_cin);
    assign w_grp_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    assign w_grp_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                      | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    assign w_grp_c[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                      | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                      | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

    assign o_cout = w_grp_c[4];

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to the requester
// that was not served last (i_ptr holds the id of the last served requester).
module rr_pick2
    import cla_share_arbiter_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = (i_ptr == REQ_ID0) ? 2'b10 : 2'b01;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/cla_share_arbiter.sv
// Time-shares one CLA adder between two requesters: round-robin accept in IDLE,
// one EXEC cycle to capture the result, then RESP holds it until the owner takes it.
module cla_share_arbiter
    import cla_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,

    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_id;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_ptr;

    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_accept0;
    logic             w_accept1;
    logic             w_rsp_hs;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    rr_pick2 u_pick (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant)
    );

    cla16 u_cla (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_cin  (r_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_ovf = signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_sum[WIDTH-1]);

    // rst gates ready so no grant is visible while reset is held.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];
    assign w_accept0  = req0_ready && req0_valid;
    assign w_accept1  = req1_ready && req1_valid;

    assign rsp0_valid = (r_state == ST_RESP) && (r_id == REQ_ID0);
    assign rsp1_valid = (r_state == ST_RESP) && (r_id == REQ_ID1);
    assign w_rsp_hs   = (r_state == ST_RESP) && ((r_id == REQ_ID0) ? rsp0_ready : rsp1_ready);

    assign rsp_sum  = r_sum;
    assign rsp_cout = r_cout;
    assign rsp_ovf  = r_ovf;
    assign busy     = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_id    <= REQ_ID0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_ptr   <= REQ_ID1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept0) begin
                        r_a     <= req0_a;
                        r_b     <= req0_b;
                        r_cin   <= req0_cin;
                        r_id    <= REQ_ID0;
                        r_state <= ST_EXEC;
                    end else if (w_accept1) begin
                        r_a     <= req1_a;
                        r_b     <= req1_b;
                        r_cin   <= req1_cin;
                        r_id    <= REQ_ID1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_sum   <= w_sum;
                    r_cout  <= w_cout;
                    r_ovf   <= w_ovf;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_ptr   <= r_id;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Randomized bench for cla_share_arbiter: a transaction-level model predicts the
// round-robin winner and the arithmetic result, a queue carries expected results.
module tb_cla_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [15:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_sum;
    logic        rsp_cout, rsp_ovf, busy;

    int          n_checks;
    int          n_errors;

    // Model state: pending request per requester and the last served id.
    bit          pend[2];
    logic [15:0] pa[2];
    logic [15:0] pb[2];
    logic        pc[2];
    int          last_id;
    logic [17:0] exp_q[$];

    cla_share_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model_add(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [31:0] s;
        logic [15:0] sum;
        logic        ovf;
        s   = 32'(a) + 32'(b) + 32'(c);
        sum = s[15:0];
        ovf = (a[15] == b[15]) && (sum[15] != a[15]);
        return {ovf, s[16], sum};
    endfunction

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b, input logic c);
        pend[r] = 1'b1;
        pa[r]   = a;
        pb[r]   = b;
        pc[r]   = c;
    endtask

    task automatic apply_reqs();
        req0_valid = pend[0];
        req0_a     = pa[0];
        req0_b     = pb[0];
        req0_cin   = pc[0];
        req1_valid = pend[1];
        req1_a     = pa[1];
        req1_b     = pb[1];
        req1_cin   = pc[1];
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
        check({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
        check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
        check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
    endtask

    // Called #1 after a rising edge with the DUT idle and at least one request pending.
    task automatic run_txn(input int hold);
        int          w;
        logic [17:0] e;
        apply_reqs();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (pend[0] && pend[1]) w = (last_id == 0) ? 1 : 0;
        else if (pend[0])       w = 0;
        else                    w = 1;
        exp_q.push_back(model_add(pa[w], pb[w], pc[w]));
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("idle_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("grant_req0", 32'(req0_ready), 32'(w == 0));
        check("grant_req1", 32'(req1_ready), 32'(w == 1));
        @(posedge clk); #1;
        pend[w] = 1'b0;
        apply_reqs();
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_req0_ready", 32'(req0_ready), 32'd0);
        check("exec_req1_ready", 32'(req1_ready), 32'd0);
        check("exec_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("exec_rsp1_valid", 32'(rsp1_valid), 32'd0);
        @(posedge clk); #1;
        e = exp_q[0];
        for (int c = 0; c <= hold; c++) begin
            check("resp_rsp0_valid", 32'(rsp0_valid), 32'(w == 0));
            check("resp_rsp1_valid", 32'(rsp1_valid), 32'(w == 1));
            check("resp_sum", 32'(rsp_sum), 32'(e[15:0]));
            check("resp_cout", 32'(rsp_cout), 32'(e[16]));
            check("resp_ovf", 32'(rsp_ovf), 32'(e[17]));
            check("resp_busy", 32'(busy), 32'd1);
            check("resp_req0_ready", 32'(req0_ready), 32'd0);
            check("resp_req1_ready", 32'(req1_ready), 32'd0);
            // The non-owner's rsp_ready toggles randomly and must be ignored.
            if (w == 0) begin
                rsp0_ready = (c == hold);
                rsp1_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp1_ready = (c == hold);
                rsp0_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        void'(exp_q.pop_front());
        last_id    = w;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("post_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        n_checks   = 0;
        n_errors   = 0;
        last_id    = 1;
        rst        = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;

        // Tie held from reset, with the carry-out and overflow corner operands.
        set_req(0, 16'hFFFF, 16'h0001, 1'b0);
        set_req(1, 16'h7FFF, 16'h0001, 1'b0);
        apply_reqs();
        #1;
        check_quiet("in_reset");
        check("in_reset_sum", 32'(rsp_sum), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check_quiet("reset_held");
        end
        rst = 1'b0;

        run_txn(0);
        run_txn(0);
        set_req(0, 16'h00FF, 16'h0000, 1'b1);
        set_req(1, 16'h1234, 16'h0FF0, 1'b0);
        run_txn(0);
        set_req(0, 16'h0001, 16'h0002, 1'b0);
        run_txn(5);
        run_txn(0);

        // Single request from requester 0.
        set_req(0, 16'h1234, 16'h0FF0, 1'b0);
        run_txn(0);

        // Reset asserted while an accepted operation is in EXEC.
        set_req(0, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        set_req(1, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        apply_reqs();
        w = (last_id == 0) ? 1 : 0;
        #1;
        check("pre_rst_grant_req1", 32'(req1_ready), 32'(w == 1));
        @(posedge clk); #1;
        check("pre_rst_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_quiet("mid_op_reset");
        check("mid_op_reset_sum", 32'(rsp_sum), 32'd0);
        check("mid_op_reset_cout", 32'(rsp_cout), 32'd0);
        pend[w] = 1'b0;
        apply_reqs();
        @(posedge clk); #1;
        check_quiet("mid_op_reset_edge");
        rst     = 1'b0;
        last_id = 1;
        set_req(w, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        run_txn(1);

        // Random traffic, including occasional withdrawal of a pending request.
        for (int t = 0; t < 80; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 2) != 0))
                    set_req(r, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            end
            if (pend[0] && pend[1] && ($urandom_range(0, 7) == 0))
                pend[$urandom_range(0, 1)] = 1'b0;
            if (!pend[0] && !pend[1]) begin
                apply_reqs();
                #1;
                check_quiet("rand_idle");
                @(posedge clk); #1;
            end else begin
                run_txn($urandom_range(0, 3));
            end
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cla_share_arbiter.md
CLA_SHARE_ARBITER -- requirements
Module: cla_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/sum width; only 16 is supported.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an add operation pending.
REQ-005 Port: req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 Port: req0_a, req0_b  input  16 each  requester 0 operands.
REQ-007 Port: req0_cin  input  1  requester 0 carry-in.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_cin  same directions/widths/meanings for requester 1.
REQ-009 Port: rsp0_valid  output  1  result for requester 0 available.
REQ-010 Port: rsp0_ready  input  1  requester 0 takes the result.
REQ-011 Port: rsp1_valid, rsp1_ready  same for requester 1.
REQ-012 Port: rsp_sum  output  16  result sum, shared by both response channels.
REQ-013 Port: rsp_cout  output  1  result carry-out.
REQ-014 Port: rsp_ovf  output  1  two's-complement signed overflow of the result.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; encoding is not observable outside the block.
REQ-017 IDLE: ready goes to at most one requester, combinationally from the valids and the priority pointer.
REQ-018 Arbitration: one valid wins; both valid -> the requester not granted last wins (round-robin).
REQ-019 Accept happens on a rising edge with valid&&ready: a, b, cin and the requester id are latched into the operand registers, FSM -> EXEC.
REQ-020 The operand registers feed one shared 16-bit carry-lookahead adder; there is no other add path.
REQ-021 EXEC: sum, cout and ovf are latched into the result registers, FSM -> RESP; lasts exactly one cycle.
REQ-022 RESP: only the rsp_valid of the latched id is high; rsp_sum, rsp_cout and rsp_ovf stay stable until the handshake.
REQ-023 RESP with rsp_ready of the latched id high at an edge -> FSM -> IDLE, priority pointer := latched id; the other rsp_ready is ignored.
REQ-024 Latency: accept at edge E0 -> rsp_valid high after E1; earliest next accept is the edge after the response handshake (3-cycle throughput).
REQ-025 Both req_ready outputs are 0 in EXEC and RESP; both rsp_valid outputs are 0 in IDLE and EXEC.
REQ-026 Arithmetic: {cout,sum} = a + b + cin, modulo 2^17.
REQ-027 ovf = (a[15]==b[15]) && (sum[15]!=a[15]).
REQ-028 A requester keeps valid and operands stable until accepted; the arbiter does not lock a grant across cycles.
REQ-029 A requester dropping valid before accept is legal; re-arbitration happens every IDLE cycle.

Reset
REQ-030 rst high -> immediately: FSM=IDLE, operand/result registers=0, priority pointer=1 (requester 0 wins first tie), all ready/valid/busy outputs=0.
REQ-031 rst asserted in EXEC or RESP -> the in-flight operation is discarded with no response; the first post-reset tie is won by requester 0.
REQ-032 Release of rst takes effect at the next rising edge; the first accept is possible on that edge.

Structure
REQ-033 The shared package holds the FSM state typedef, WIDTH, and requester id constants REQ_ID0=0 and REQ_ID1=1.
REQ-034 The round-robin picker is one sub-module, rr_pick2 (inputs: two valids, pointer; outputs: one-hot grant).
REQ-035 The adder is an instance of the team's existing 16-bit CLA unit with carry-in from the operand register; no second adder instance.

Verification
REQ-036 Single op: req0 a=16'h1234, b=16'h0FF0, cin=0, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, sum=16'h2224, cout=0, ovf=0.
REQ-037 Tie: both valid from reset -> req0 served first, then req1; with both held valid, grants alternate 0,1,0,1.
REQ-038 Carry/overflow: a=16'hFFFF, b=16'h0001, cin=0 -> sum=0000, cout=1, ovf=0; a=16'h7FFF, b=16'h0001 -> sum=8000, cout=0, ovf=1.
REQ-039 Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid and sum stable, req0_ready=0 throughout, release -> IDLE next edge.
REQ-040 Reset mid-op: rst pulsed in EXEC -> no rsp_valid ever for that op; busy=0 immediately; next tie goes to req0.
REQ-041 cin path: a=16'h00FF, b=16'h0000, cin=1 -> sum=16'h0100, cout=0, ovf=0.
